// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller and the fetch-stage PC mux.
// ctrl_t bundles every per-cycle control output so priorities can assign whole words.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_JAL    = 2'd1,
    PC_BRANCH = 2'd2,
    PC_JALR   = 2'd3
  } pc_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } ctrl_state_t;

  localparam int WAIT_W = 16;

  typedef struct packed {
    logic    pc_en;
    pc_sel_t pc_sel;
    logic    ifid_stall;
    logic    ifid_squash;
    logic    idex_stall;
    logic    idex_squash;
    logic    exmem_stall;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{pc_en: 1'b1, pc_sel: PC_SEQ, ifid_stall: 1'b0,
                                 ifid_squash: 1'b0, idex_stall: 1'b0,
                                 idex_squash: 1'b0, exmem_stall: 1'b0};

  // Whole pipe holds; nothing is squashed so the frozen instructions survive.
  localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, pc_sel: PC_SEQ, ifid_stall: 1'b1,
                                    ifid_squash: 1'b0, idex_stall: 1'b1,
                                    idex_squash: 1'b0, exmem_stall: 1'b1};

  localparam ctrl_t CTRL_RESET = '{pc_en: 1'b0, pc_sel: PC_SEQ, ifid_stall: 1'b0,
                                   ifid_squash: 1'b1, idex_stall: 1'b0,
                                   idex_squash: 1'b1, exmem_stall: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                  cnt_d = '0;
    else if (inc_i && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipe: interlocks, redirects,
// dmem wait freeze with timeout, and saturating stall/flush counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic             id_jal_i,
  input  logic             ex_valid_i,
  input  logic             ex_dmem_rd_en_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_branch_taken_i,
  input  logic             ex_jalr_i,
  input  logic             imem_ready_i,
  input  logic             mem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_en_o,
  output logic [1:0]       pc_sel_o,
  output logic             ifid_stall_o,
  output logic             ifid_squash_o,
  output logic             idex_stall_o,
  output logic             idex_squash_o,
  output logic             exmem_stall_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

  ctrl_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  ctrl_t             ctrl;
  logic              redirect;
  logic              frozen, ex_redir, load_use, jal;

  assign ex_redir = ex_valid_i & (ex_branch_taken_i | ex_jalr_i);
  assign load_use = ex_valid_i & ex_dmem_rd_en_i & (ex_rd_i != 5'd0) & id_valid_i &
                    ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) |
                     (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));
  assign jal      = id_valid_i & id_jal_i;
  // The ack cycle of a wait is not frozen: it takes normal priorities.
  assign frozen   = ((state_q == RUN) & mem_req_i & ~dmem_ack_i) |
                    ((state_q == MEM_WAIT) & ~dmem_ack_i) |
                    (state_q == ERR);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      RUN: if (mem_req_i && !dmem_ack_i) begin
        state_d = MEM_WAIT;
        wait_d  = '0;
      end
      MEM_WAIT: begin
        if (dmem_ack_i) begin
          state_d = RUN;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_q + 1'b1 == TIMEOUT) state_d = ERR;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    ctrl     = CTRL_RUN;
    redirect = 1'b0;
    if (frozen) begin
      ctrl = CTRL_FREEZE;
    end else if (ex_redir) begin
      ctrl.pc_sel      = ex_jalr_i ? PC_JALR : PC_BRANCH;
      ctrl.ifid_squash = 1'b1;
      ctrl.idex_squash = 1'b1;
      redirect         = 1'b1;
    end else if (load_use) begin
      // One bubble; the load has left EX next cycle so this never repeats.
      ctrl.pc_en       = 1'b0;
      ctrl.ifid_stall  = 1'b1;
      ctrl.idex_squash = 1'b1;
    end else if (jal) begin
      ctrl.pc_sel      = PC_JAL;
      ctrl.ifid_squash = 1'b1;
      redirect         = 1'b1;
    end else if (!imem_ready_i) begin
      ctrl.pc_en       = 1'b0;
      ctrl.ifid_squash = 1'b1;
    end
    if (rst_i) begin
      ctrl     = CTRL_RESET;
      redirect = 1'b0;
    end
  end

  assign pc_en_o       = ctrl.pc_en;
  assign pc_sel_o      = ctrl.pc_sel;
  assign ifid_stall_o  = ctrl.ifid_stall;
  assign ifid_squash_o = ctrl.ifid_squash;
  assign idex_stall_o  = ctrl.idex_stall;
  assign idex_squash_o = ctrl.idex_squash;
  assign exmem_stall_o = ctrl.exmem_stall;
  assign bus_err_o     = (state_q == ERR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_i (rst_i),
    .inc_i (~ctrl.pc_en),
    .clr_i (1'b0),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_i (rst_i),
    .inc_i (redirect),
    .clr_i (1'b0),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected control words queued per step, counters modelled.
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             id_valid_i, id_uses_rs1_i, id_uses_rs2_i, id_jal_i;
  logic [4:0]       id_rs1_i, id_rs2_i, ex_rd_i;
  logic             ex_valid_i, ex_dmem_rd_en_i, ex_branch_taken_i, ex_jalr_i;
  logic             imem_ready_i, mem_req_i, dmem_ack_i;
  logic             pc_en_o, ifid_stall_o, ifid_squash_o, idex_stall_o, idex_squash_o;
  logic             exmem_stall_o, bus_err_o;
  logic [1:0]       pc_sel_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int               n_assert = 0;
  int               n_fail   = 0;
  logic [8:0]       exp_q[$];
  logic [CNT_W-1:0] m_stall, m_flush;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst_i             (rst_i),
    .id_valid_i        (id_valid_i),
    .id_rs1_i          (id_rs1_i),
    .id_rs2_i          (id_rs2_i),
    .id_uses_rs1_i     (id_uses_rs1_i),
    .id_uses_rs2_i     (id_uses_rs2_i),
    .id_jal_i          (id_jal_i),
    .ex_valid_i        (ex_valid_i),
    .ex_dmem_rd_en_i   (ex_dmem_rd_en_i),
    .ex_rd_i           (ex_rd_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .ex_jalr_i         (ex_jalr_i),
    .imem_ready_i      (imem_ready_i),
    .mem_req_i         (mem_req_i),
    .dmem_ack_i        (dmem_ack_i),
    .pc_en_o           (pc_en_o),
    .pc_sel_o          (pc_sel_o),
    .ifid_stall_o      (ifid_stall_o),
    .ifid_squash_o     (ifid_squash_o),
    .idex_stall_o      (idex_stall_o),
    .idex_squash_o     (idex_squash_o),
    .exmem_stall_o     (exmem_stall_o),
    .bus_err_o         (bus_err_o),
    .stall_cnt_o       (stall_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  // {pc_en, pc_sel, ifid_stall, ifid_squash, idex_stall, idex_squash, exmem_stall, bus_err}
  function automatic logic [8:0] vec(logic pe, logic [1:0] sel, logic fs, logic fq,
                                     logic is, logic iq, logic es, logic be);
    return {pe, sel, fs, fq, is, iq, es, be};
  endfunction

  function automatic logic [8:0] obs();
    return {pc_en_o, pc_sel_o, ifid_stall_o, ifid_squash_o, idex_stall_o,
            idex_squash_o, exmem_stall_o, bus_err_o};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_uses_rs1_i = 0; id_uses_rs2_i = 0;
    id_jal_i = 0; ex_valid_i = 0; ex_dmem_rd_en_i = 0; ex_rd_i = 0;
    ex_branch_taken_i = 0; ex_jalr_i = 0; imem_ready_i = 1; mem_req_i = 0; dmem_ack_i = 0;
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic step(string tag, logic [8:0] e);
    logic [8:0] g;
    exp_q.push_back(e);
    #4;
    g = exp_q.pop_front();
    check(tag, 32'(obs()), 32'(g));
    check({tag, "/stall_cnt"}, 32'(stall_cnt_o), 32'(m_stall));
    check({tag, "/flush_cnt"}, 32'(flush_cnt_o), 32'(m_flush));
    if (!g[8] && m_stall != '1) m_stall++;
    if (g[7:6] != 2'd0 && m_flush != '1) m_flush++;
    @(posedge clk); #1;
  endtask

  task automatic check_reset(string tag, logic [8:0] rv);
    check(tag, 32'(obs()), 32'(rv));
    check({tag, "/stall_cnt"}, 32'(stall_cnt_o), 32'd0);
    check({tag, "/flush_cnt"}, 32'(flush_cnt_o), 32'd0);
    m_stall = '0;
    m_flush = '0;
  endtask

  initial begin
    logic [8:0] N, LU, BR, JR, JL, FW, FZ, EV, RV;
    N  = vec(1, 2'd0, 0, 0, 0, 0, 0, 0);
    LU = vec(0, 2'd0, 1, 0, 0, 1, 0, 0);
    BR = vec(1, 2'd2, 0, 1, 0, 1, 0, 0);
    JR = vec(1, 2'd3, 0, 1, 0, 1, 0, 0);
    JL = vec(1, 2'd1, 0, 1, 0, 0, 0, 0);
    FW = vec(0, 2'd0, 0, 1, 0, 0, 0, 0);
    FZ = vec(0, 2'd0, 1, 0, 1, 0, 1, 0);
    EV = vec(0, 2'd0, 1, 0, 1, 0, 1, 1);
    RV = vec(0, 2'd0, 0, 1, 0, 1, 0, 0);

    rst_i = 1;
    idle_in();
    @(negedge clk);
    check_reset("reset", RV);
    rst_i = 0;
    @(posedge clk); #1;

    step("idle", N);
    idle_in(); ex_valid_i = 1; ex_dmem_rd_en_i = 1; ex_rd_i = 5;
    id_valid_i = 1; id_uses_rs1_i = 1; id_rs1_i = 5;
    step("loaduse_rs1", LU);
    ex_valid_i = 0;
    step("after_loaduse", N);
    idle_in(); ex_valid_i = 1; ex_dmem_rd_en_i = 1; ex_rd_i = 0;
    id_valid_i = 1; id_uses_rs1_i = 1; id_rs1_i = 0;
    step("load_x0", N);
    idle_in(); ex_valid_i = 1; ex_dmem_rd_en_i = 1; ex_rd_i = 7;
    id_valid_i = 1; id_uses_rs1_i = 1; id_rs1_i = 3; id_uses_rs2_i = 1; id_rs2_i = 7;
    step("loaduse_rs2", LU);
    idle_in(); ex_valid_i = 1; ex_dmem_rd_en_i = 1; ex_rd_i = 3;
    id_valid_i = 1; id_rs1_i = 3; id_uses_rs2_i = 1; id_rs2_i = 4;
    step("rs1_not_used", N);
    idle_in(); ex_valid_i = 1; ex_dmem_rd_en_i = 1; ex_rd_i = 5; ex_branch_taken_i = 1;
    id_valid_i = 1; id_uses_rs1_i = 1; id_rs1_i = 5;
    step("branch_over_lu", BR);
    idle_in(); ex_valid_i = 1; ex_jalr_i = 1;
    step("jalr", JR);
    idle_in(); id_valid_i = 1; id_jal_i = 1;
    step("jal", JL);
    ex_valid_i = 1; ex_dmem_rd_en_i = 1; ex_rd_i = 9; id_uses_rs1_i = 1; id_rs1_i = 9;
    step("jal_with_lu", LU);
    ex_valid_i = 0;
    step("jal_after_lu", JL);
    idle_in(); imem_ready_i = 0;
    step("fetch_wait", FW);
    ex_valid_i = 1; ex_branch_taken_i = 1;
    step("branch_fetch_wait", BR);

    idle_in(); mem_req_i = 1; ex_valid_i = 1; ex_branch_taken_i = 1;
    for (int i = 0; i < 3; i++) step($sformatf("memwait_freeze%0d", i), FZ);
    dmem_ack_i = 1;
    step("memwait_ack_branch", BR);
    idle_in();
    step("memwait_done", N);

    idle_in(); mem_req_i = 1;
    step("tmo_run_freeze", FZ);
    for (int i = 0; i < 4; i++) step($sformatf("tmo_wait%0d", i), FZ);
    step("tmo_err", EV);
    idle_in(); dmem_ack_i = 1;
    for (int i = 0; i < 6; i++) step($sformatf("err_sticky%0d", i), EV);

    #1 rst_i = 1;
    #1 check_reset("async_reset", RV);
    @(negedge clk);
    rst_i = 0;
    @(posedge clk); #1;
    idle_in();
    step("post_reset_idle", N);
    ex_valid_i = 1; ex_dmem_rd_en_i = 1; ex_rd_i = 2; id_valid_i = 1;
    id_uses_rs2_i = 1; id_rs2_i = 2;
    step("post_reset_lu", LU);
    idle_in();
    step("post_reset_final", N);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
